// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: NUM_REQ request lines, one registered one-hot grant per clock.
// Define RR_LOCK_EN to let a winner keep the grant for up to MAX_HOLD consecutive cycles.
module rr_arbiter_n #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 4,
    parameter int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req_vector,
    output logic [NUM_REQ-1:0] grant_vector,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    if (NUM_REQ < 2 || NUM_REQ > 32 || MAX_HOLD < 1) begin : g_bad_param
        $error("rr_arbiter_n: NUM_REQ must be 2..32 and MAX_HOLD >= 1");
    end

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_vector_q, grant_vector_d;
    logic               grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;

    logic               found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   win_next;
    int                 scan_pos;

`ifdef RR_LOCK_EN
    localparam int HC_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
`endif

    // Circular scan starting at ptr; the first asserted line is the winner.
    always_comb begin
        found    = 1'b0;
        win_idx  = ptr_q;
        scan_pos = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_pos = int'(ptr_q) + k;
            if (scan_pos >= NUM_REQ) begin
                scan_pos = scan_pos - NUM_REQ;
            end
            if (!found && req_vector[scan_pos[IDX_W-1:0]]) begin
                found   = 1'b1;
                win_idx = scan_pos[IDX_W-1:0];
            end
        end
        win_next = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IDX_W'(1);
    end

    always_comb begin
        ptr_d          = ptr_q;
        grant_vector_d = '0;
        grant_valid_d  = 1'b0;
        grant_idx_d    = grant_idx_q;
`ifdef RR_LOCK_EN
        state_d        = state_q;
        owner_d        = owner_q;
        hold_cnt_d     = hold_cnt_q;
        if (!enable) begin
            state_d    = ARB;
            hold_cnt_d = '0;
        end else if (state_q == HOLD && req_vector[owner_q] &&
                     hold_cnt_q < HC_W'(MAX_HOLD)) begin
            grant_vector_d = NUM_REQ'(1) << owner_q;
            grant_valid_d  = 1'b1;
            grant_idx_d    = owner_q;
            hold_cnt_d     = hold_cnt_q + HC_W'(1);
        end else if (found) begin
            // ptr already sits past the previous owner, so a fresh scan is fair.
            grant_vector_d = NUM_REQ'(1) << win_idx;
            grant_valid_d  = 1'b1;
            grant_idx_d    = win_idx;
            ptr_d          = win_next;
            state_d        = HOLD;
            owner_d        = win_idx;
            hold_cnt_d     = HC_W'(1);
        end else begin
            state_d    = ARB;
            hold_cnt_d = '0;
        end
`else
        if (enable && found) begin
            grant_vector_d = NUM_REQ'(1) << win_idx;
            grant_valid_d  = 1'b1;
            grant_idx_d    = win_idx;
            ptr_d          = win_next;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q          <= '0;
            grant_vector_q <= '0;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
`ifdef RR_LOCK_EN
            state_q        <= ARB;
            owner_q        <= '0;
            hold_cnt_q     <= '0;
`endif
        end else begin
            ptr_q          <= ptr_d;
            grant_vector_q <= grant_vector_d;
            grant_valid_q  <= grant_valid_d;
            grant_idx_q    <= grant_idx_d;
`ifdef RR_LOCK_EN
            state_q        <= state_d;
            owner_q        <= owner_d;
            hold_cnt_q     <= hold_cnt_d;
`endif
        end
    end

    assign grant_vector = grant_vector_q;
    assign grant_valid  = grant_valid_q;
    assign grant_idx    = grant_idx_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: a 4-requester and a 5-requester instance driven side by side,
// checked against a circular-scan reference model plus directed constant expectations.
module tb_rr_arbiter_n;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       en4 = 1'b0;
    logic [3:0] req4 = '0;
    logic [3:0] gv4;
    logic       gval4;
    logic [1:0] gi4;
    logic       en5 = 1'b0;
    logic [4:0] req5 = '0;
    logic [4:0] gv5;
    logic       gval5;
    logic [2:0] gi5;

    int n_checks = 0;
    int n_err    = 0;

`ifdef RR_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    always #5 CLK = ~CLK;

    rr_arbiter_n #(.NUM_REQ(4), .MAX_HOLD(3)) u_dut4 (
        .CLK(CLK), .RST(RST), .enable(en4), .req_vector(req4),
        .grant_vector(gv4), .grant_valid(gval4), .grant_idx(gi4)
    );

    rr_arbiter_n #(.NUM_REQ(5), .MAX_HOLD(2)) u_dut5 (
        .CLK(CLK), .RST(RST), .enable(en5), .req_vector(req5),
        .grant_vector(gv5), .grant_valid(gval5), .grant_idx(gi5)
    );

    // Reference model state, one slot per instance (0: 4 lines, 1: 5 lines).
    int          nreq[2]  = '{4, 5};
    int          mhold[2] = '{3, 2};
    int          m_ptr[2];
    int          m_idx[2];
    int          m_owner[2];
    int          m_tenure[2];
    logic [31:0] m_gv[2];
    logic        m_valid[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int i, input bit rst_i, input bit en_i, input logic [31:0] rq);
        int w;
        bit hit;
        if (rst_i) begin
            m_ptr[i] = 0; m_idx[i] = 0; m_gv[i] = 0; m_valid[i] = 0; m_tenure[i] = 0;
        end else if (!en_i) begin
            m_gv[i] = 0; m_valid[i] = 0; m_tenure[i] = 0;
        end else if (LOCK && m_tenure[i] > 0 && rq[m_owner[i]] && m_tenure[i] < mhold[i]) begin
            m_gv[i] = 32'd1 << m_owner[i];
            m_valid[i] = 1;
            m_idx[i] = m_owner[i];
            m_tenure[i]++;
        end else begin
            hit = 0;
            w = 0;
            for (int k = 0; k < nreq[i]; k++) begin
                if (!hit && rq[(m_ptr[i] + k) % nreq[i]]) begin
                    hit = 1;
                    w = (m_ptr[i] + k) % nreq[i];
                end
            end
            if (hit) begin
                m_gv[i] = 32'd1 << w;
                m_valid[i] = 1;
                m_idx[i] = w;
                m_ptr[i] = (w + 1) % nreq[i];
                m_owner[i] = w;
                m_tenure[i] = 1;
            end else begin
                m_gv[i] = 0; m_valid[i] = 0; m_tenure[i] = 0;
            end
        end
    endtask

    // Drive inputs away from the edge, advance one clock, compare both instances.
    task automatic step(input bit rst_i, input bit e4, input logic [3:0] r4,
                        input bit e5, input logic [4:0] r5);
        RST = rst_i; en4 = e4; req4 = r4; en5 = e5; req5 = r5;
        model_step(0, rst_i, e4, 32'(r4));
        model_step(1, rst_i, e5, 32'(r5));
        @(posedge CLK);
        #1;
        chk("gv4",   32'(gv4),   m_gv[0]);
        chk("gval4", 32'(gval4), 32'(m_valid[0]));
        chk("gi4",   32'(gi4),   32'(m_idx[0]));
        chk("gv5",   32'(gv5),   m_gv[1]);
        chk("gval5", 32'(gval5), 32'(m_valid[1]));
        chk("gi5",   32'(gi5),   32'(m_idx[1]));
    endtask

    logic [3:0] exp_a[5];
    logic [4:0] exp_b[3];
    int         guard;
    logic [3:0] r4;
    logic [4:0] r5;

    initial begin
        if (LOCK) begin
            exp_a = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
            exp_b = '{5'b10000, 5'b10000, 5'b00001};
        end else begin
            exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            exp_b = '{5'b10000, 5'b00001, 5'b00010};
        end

        // Reset held two cycles with every line requesting.
        for (int c = 0; c < 2; c++) begin
            step(1, 1, 4'b1111, 1, 5'b11111);
            chk("rst_gv4", 32'(gv4), 0);
            chk("rst_gval4", 32'(gval4), 0);
            chk("rst_gi4", 32'(gi4), 0);
        end

        // Rotation with all four lines held.
        for (int c = 0; c < 5; c++) begin
            step(0, 1, 4'b1111, 1, 5'b00000);
            chk($sformatf("rot_%0d", c), 32'(gv4), 32'(exp_a[c]));
        end
        step(0, 1, 4'b1101, 1, 5'b00000);
        chk("drop1", 32'(gv4), 32'(4'b0100));

        // Enable freeze after the first grant to requester 2.
        step(1, 1, 4'b0000, 0, 5'b00000);
        guard = 0;
        do begin
            step(0, 1, 4'b1111, 0, 5'b00000);
            guard++;
        end while (!(m_valid[0] && m_idx[0] == 2) && guard < 20);
        chk("reach_idx2", 32'(gi4), 2);
        for (int c = 0; c < 3; c++) begin
            step(0, 0, 4'b1111, 0, 5'b00000);
            chk("dis_gv4", 32'(gv4), 0);
            chk("dis_gval4", 32'(gval4), 0);
        end
        step(0, 1, 4'b1111, 0, 5'b00000);
        chk("reen_gv4", 32'(gv4), 32'(4'b1000));

        // Alternating pair on dut4, pointer wrap on the 5-line dut.
        step(1, 1, 4'b0000, 1, 5'b00000);
        step(0, 1, 4'b0010, 1, 5'b10000);
        chk("w5_0", 32'(gv5), 32'(exp_b[0]));
        step(0, 1, 4'b1010, 1, 5'b11111);
        chk("w5_1", 32'(gv5), 32'(exp_b[1]));
        step(0, 1, 4'b1010, 1, 5'b11111);
        chk("w5_2", 32'(gv5), 32'(exp_b[2]));
        step(0, 1, 4'b1010, 1, 5'b11111);
        step(0, 1, 4'b1010, 1, 5'b11111);
        step(0, 1, 4'b0000, 1, 5'b00000);
        chk("idle_gval4", 32'(gval4), 0);
        chk("idle_gi4", 32'(gi4), LOCK ? 3 : 1);

        // Randomized traffic with occasional reset and enable drops.
        r4 = '0;
        r5 = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) != 0) r4 = 4'($urandom);
            if ($urandom_range(0, 3) != 0) r5 = 5'($urandom);
            step($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0, r4,
                 $urandom_range(0, 7) != 0, r5);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised round-robin bus arbiter for the router datapath: accepts `NUM_REQ` request lines and issues at most one registered, one-hot grant per clock. Priority rotates after every grant, with the highest priority going to the requester after the last winner, instead of rotating on a fixed cycle schedule. It replaces the fixed 4-requester arbiter and sits between the input-port request logic and the crossbar select.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..32, power of two not required.
- `MAX_HOLD`, 4: maximum consecutive cycles one requester may keep a grant when `RR_LOCK_EN` is defined; legal range ≥1.
- `IDX_W`, derived `max(1, $clog2(NUM_REQ))`: width of the index and pointer. Not to be overridden.

- `CLK`  in  1  single clock; all logic on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `enable`  in  1  active high; when low, no grant is issued and the priority pointer is frozen.
- `req_vector`  in  NUM_REQ  request lines; bit i is requester i.
- `grant_vector`  out  NUM_REQ  registered grant, one-hot or zero.
- `grant_valid`  out  1  registered; high iff `grant_vector` is nonzero.
- `grant_idx`  out  IDX_W  registered binary index of the granted requester; holds the last winner when `grant_valid` is 0.

## Operation
- Internal state: `ptr` (IDX_W bits), the highest-priority index. With `RR_LOCK_EN` defined, there is also an FSM {ARB, HOLD}, an `owner` index and `hold_cnt` (`$clog2(MAX_HOLD+1)` bits).
- ARB, `enable`=1: scan `ptr`, `ptr+1`, …, `NUM_REQ-1`, 0, …, `ptr-1`. The first asserted request wins.
  - On a win: `grant_vector` ← one-hot(w), `grant_idx` ← w, `grant_valid` ← 1, `ptr` ← (w+1) mod `NUM_REQ`.
  - `ptr` wraps from `NUM_REQ-1` to 0 for any `NUM_REQ`, including non-powers of two.
- No request asserted: `grant_vector` ← 0, `grant_valid` ← 0, `ptr` and `grant_idx` unchanged.
- `enable`=0: `grant_vector` ← 0, `grant_valid` ← 0. `ptr` is unchanged, and the FSM returns to ARB with `hold_cnt` cleared.
- Lock (HOLD) behaviour:
  - In ARB, a win moves the FSM to HOLD with `owner`=w and `hold_cnt`=1.
  - In HOLD, if `req_vector[owner]`=1 and `hold_cnt` < `MAX_HOLD`: the grant is repeated and `hold_cnt` increments.
  - Otherwise the block re-arbitrates in that same cycle using the ARB rule (`ptr` already points past `owner`). The result is either a new tenure with `hold_cnt`=1, or ARB with no grant.
  - A sole remaining requester may win again immediately after its tenure expires.
- With `MAX_HOLD`=1 the lock mode behaves identically to the unlocked mode.
- Requests asserted in the same cycle are all resolved by the pointer order. No request is lost; an unserved requester must keep its line high.

## Timing
- Reset (`RST`=1 at a rising edge):
  - Outputs: `grant_vector`=0, `grant_valid`=0, `grant_idx`=0.
  - Internal state: `ptr`=0, FSM=ARB, `hold_cnt`=0.
  - `RST` dominates `enable` and requests. Reset asserted mid-tenure drops the grant on the next edge.
- Latency: `req_vector` sampled at edge n produces the grant visible after edge n, i.e. one register stage. There is no combinational path from input to output.
- Throughput: one grant decision per cycle. A new winner may appear on consecutive cycles.
- Fairness bound:
  - Unlocked: a continuously requesting line is granted within `NUM_REQ` cycles.
  - Locked: within `(NUM_REQ-1)*MAX_HOLD+1` cycles.
- A request deasserting in the same cycle that it would be granted is not granted.

## Configuration
- `RR_LOCK_EN` defined: the ARB/HOLD FSM, `owner` and `hold_cnt` are compiled in, and grants persist as described under Operation.
- `RR_LOCK_EN` undefined: no FSM and no hold counter. The block re-arbitrates every cycle, `MAX_HOLD` is ignored, and all other behaviour is identical.

## Test plan
- Reset with `NUM_REQ`=4, `req_vector`=1111, `enable`=1, `RST` high for 2 cycles → `grant_vector`=0000 and `grant_valid`=0 throughout. On the first edge after release → `grant_vector`=0001, `grant_idx`=0.
- Unlocked, `NUM_REQ`=4, `req_vector`=1111 held → `grant_vector` sequence 0001, 0010, 0100, 1000, 0001.
- Unlocked, grant to requester 1, then `req_vector`=1010 held → 1000, 0010, 1000, 0010. Then `req_vector`=0000 → `grant_vector`=0000, `grant_valid`=0, `grant_idx` stays 1.
- `NUM_REQ`=5, `req_vector`=10000 for 1 cycle, then 11111 → grant 10000, then 00001 (pointer wrap from 4 to 0), then 00010.
- `RR_LOCK_EN`, `MAX_HOLD`=3, `req_vector`=1111 held → 0001 for 3 cycles, then 0010 for 3 cycles. Dropping `req_vector[1]` after its first grant cycle → 0100 on the next cycle.
- `enable` low for 3 cycles after a grant to requester 2 with `req_vector`=1111 → `grant_vector`=0000 during those cycles. On re-enable → 1000 (pointer frozen at 3).
